// File: rtl/heap_drain_ctrl.sv
// Purpose : drains the sorted two-bank heap min-first, one 4-element word per read, as a byte stream.
// Latency : start to first sym_valid is 3 cycles when heap_valid follows heap_rd by one cycle; 4 bytes per 6 cycles.
// Backpr. : sym_data/sym_valid hold until sym_ready; no new heap read is issued until the current word is consumed.
//
// Ports:
//   clk, rstN                : clock, asynchronous active-low reset
//   start, num_elem          : begin a drain of num_elem elements (clamped to 2**(CNT_W-1))
//   heap_rd/heap_dout/
//   heap_valid/heap_empty    : single-outstanding word read interface to the heap
//   sym_valid/sym_data/
//   sym_last/sym_ready       : byte stream toward the tree builder
//   busy, done, err          : drain in progress, completion pulse, sticky early-empty error
module heap_drain_ctrl #(
  parameter int ELEM_W = 8,
  parameter int CNT_W  = 9
) (
  input  logic                clk,
  input  logic                rstN,
  input  logic                start,
  input  logic [CNT_W-1:0]    num_elem,
  output logic                heap_rd,
  input  logic [4*ELEM_W-1:0] heap_dout,
  input  logic                heap_valid,
  input  logic                heap_empty,
  output logic                sym_valid,
  output logic [ELEM_W-1:0]   sym_data,
  output logic                sym_last,
  input  logic                sym_ready,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_EMIT = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  // Largest drainable count: the top bit of the count field alone (256 for CNT_W=9).
  localparam logic [CNT_W-1:0] MAX_ELEM = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [2:0]          state;
  logic [CNT_W-1:0]    remaining;
  logic [1:0]          idx;
  logic [4*ELEM_W-1:0] word;
  logic                fetched;
  logic                err_q;
  logic                done_q;
  logic                xfer;
  logic                empty_stop;

  assign xfer       = sym_valid & sym_ready;
  // An empty heap only counts as an error once this drain has already pulled a word;
  // the very first read is always issued.
  assign empty_stop = heap_empty & fetched;

  assign heap_rd   = (state == S_REQ) & ~empty_stop;
  assign sym_valid = (state == S_EMIT);
  assign sym_last  = sym_valid & (remaining == ONE);
  assign busy      = (state != S_IDLE);
  assign done      = done_q;
  assign err       = err_q;

  // Element 0 is the most significant byte of the word.
  always_comb begin
    sym_data = word[4*ELEM_W-1 -: ELEM_W];
    case (idx)
      2'd0:    sym_data = word[4*ELEM_W-1 -: ELEM_W];
      2'd1:    sym_data = word[3*ELEM_W-1 -: ELEM_W];
      2'd2:    sym_data = word[2*ELEM_W-1 -: ELEM_W];
      default: sym_data = word[ELEM_W-1 -: ELEM_W];
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state     <= S_IDLE;
      remaining <= '0;
      idx       <= 2'd0;
      word      <= '0;
      fetched   <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            remaining <= (num_elem > MAX_ELEM) ? MAX_ELEM : num_elem;
            err_q     <= 1'b0;
            fetched   <= 1'b0;
            state     <= (num_elem == '0) ? S_FIN : S_REQ;
          end
        end
        S_REQ: begin
          if (empty_stop) begin
            err_q <= 1'b1;
            state <= S_FIN;
          end else begin
            fetched <= 1'b1;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (heap_valid) begin
            word  <= heap_dout;
            idx   <= 2'd0;
            state <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (xfer) begin
            remaining <= remaining - ONE;
            idx       <= idx + 2'd1;
            // Ending on the count drops any unused trailing bytes of a partial word.
            if (remaining == ONE) begin
              state <= S_FIN;
            end else if (idx == 2'd3) begin
              state <= S_REQ;
            end
          end
        end
        S_FIN: begin
          // Registered so the pulse lands in the first idle cycle.
          done_q <= ~err_q;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/heap_drain_ctrl.md
Name: heap_drain_ctrl

Overview:
- Sequences ascending-order (min-first) drain of the sorted two-bank heap after the sorter has filled it.
- Issues single-cycle word reads (4 elements per word) and captures each returned word.
- Serialises each word into a byte stream with valid/ready backpressure toward the Huffman tree builder.
- Stops after a programmed element count and reports done, or reports an error if the heap runs dry early.

Parameters:
ELEM_W, 8, element width in bits; word width is 4*ELEM_W.
CNT_W, 9, width of element count (max 256 elements).

Ports:
clk  input  1  system clock
rstN  input  1  reset; asynchronous, active-low
start  input  1  pulse: heap fully loaded, begin drain
num_elem  input  CNT_W  valid element count, sampled on accepted start
heap_rd  output  1  word read request to heap, single-cycle pulse
heap_dout  input  4*ELEM_W  read word; element order MSB byte first
heap_valid  input  1  heap_dout valid this cycle
heap_empty  input  1  heap read pointer exhausted
sym_valid  output  1  output byte valid
sym_data  output  ELEM_W  output element
sym_last  output  1  marks final element of drain
sym_ready  input  1  downstream accepts byte
busy  output  1  drain in progress
done  output  1  one-cycle pulse at normal completion
err  output  1  sticky: heap_empty seen while elements remained; cleared by next accepted start

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, word register 0.
- States: IDLE, REQ, WAIT, EMIT, FIN.
- IDLE:
  - start accepted only here; latch num_elem into remaining count, clear err, busy=1.
  - num_elem==0: go to FIN, no heap_rd issued.
  - otherwise go to REQ.
  - start while busy is ignored.
- REQ:
  - If heap_empty=1 and a prior word has already been fetched this drain: set err, go to FIN, no heap_rd.
  - Else assert heap_rd for exactly one cycle, go to WAIT.
- WAIT:
  - Capture heap_dout into the word register on heap_valid (expected 1 cycle after heap_rd).
  - Set byte index to 0, go to EMIT.
  - Stays in WAIT indefinitely if heap_valid never arrives.
- EMIT:
  - sym_valid=1; sym_data = byte[idx], where idx0 = bits[4E-1:3E] and idx3 = bits[E-1:0].
  - A byte transfers when sym_valid & sym_ready; sym_data/sym_valid are held stable until then.
  - On each transfer: remaining -= 1, idx += 1.
  - sym_last=1 when remaining==1.
  - Transfer with remaining==1: go to FIN.
  - Transfer with idx==3 and remaining>1: go to REQ.
  - Partial final word: unused trailing bytes are discarded.
- FIN:
  - done=1 for one cycle only if err==0.
  - busy=0 next cycle; return to IDLE.
- heap_rd is never asserted outside REQ; at most one outstanding read.
- Word fetch count = ceil(num_elem/4); max 64 words for 256 elements.
- num_elem > 256: clamped to 256.
- Reset mid-drain: immediate return to IDLE, all outputs 0; heap pointer state is the heap's concern.
- Latency: start to first sym_valid = 3 cycles (IDLE→REQ→WAIT→EMIT) with heap_valid at 1 cycle.
- Throughput with sym_ready held high: 4 bytes per 6 cycles.

Test Plan:
- Heap words 0x01020304, 0x05060708; start, num_elem=8, sym_ready=1:
  - bytes 01..08 in order; sym_last on 08; done pulse; exactly 2 heap_rd pulses.
- num_elem=6, same data: bytes 01..06; sym_last on 06; 07/08 dropped; 2 heap_rd pulses; done.
- num_elem=0: no heap_rd, no sym_valid; done pulses 2 cycles after start.
- Backpressure:
  - toggle sym_ready 1,0,0,1 per cycle with num_elem=4 → sym_data stable while not ready, 4 transfers total.
  - next heap_rd is not issued before the 4th transfer.
- heap_empty asserted after the first word with num_elem=12: 4 bytes out, then err=1, no done, busy drops.
- start re-pulsed mid-drain → ignored; rstN low mid-EMIT → sym_valid, busy, heap_rd all 0 asynchronously; fresh start works.
